hs_tx_serializer: RTL



---
 rtl/hs_tx_serializer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hs_tx_serializer.sv
// HS transmit serializer: sends a sync byte, then payload bytes LSB first as bit pairs
// (one pair per DDR clock), then a trailer of the inverted last bit.
module hs_tx_serializer #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hB8,
  parameter int unsigned TRAIL_BYTES = 1
) (
  input  logic       TX_DDR_clk,
  input  logic       TX_rst_n,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic       Serial_B1,
  output logic       Serial_B2,
  output logic       Enable
);

  // Trailer spans TRAIL_BYTES byte slots of 4 clocks each.
  localparam logic [5:0] TrailLast = 6'(TRAIL_BYTES * 4 - 1);

  typedef enum logic [1:0] {StIdle, StSync, StData, StTrailer} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [5:0] tcnt_q, tcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       last_bit_q, last_bit_d;

  logic       en_q, en_d;
  logic       b1_q, b1_d;
  logic       b2_q, b2_d;
  logic       rdy_q, rdy_d;

  // Next-state: byte slot sequencing, payload capture and trailer timing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    shreg_d    = shreg_q;
    last_bit_d = last_bit_q;
    unique case (state_q)
      StIdle: begin
        if (TxRequestHS) begin
          state_d = StSync;
          cnt_d   = 2'd0;
        end
      end
      StSync, StData: begin
        if (cnt_q == 2'd3) begin
          if (TxRequestHS) begin
            shreg_d = TxDataHS;
            state_d = StData;
            cnt_d   = 2'd0;
          end else begin
            state_d    = StTrailer;
            tcnt_d     = 6'd0;
            cnt_d      = 2'd0;
            last_bit_d = (state_q == StSync) ? SYNC_BYTE[7] : shreg_q[7];
          end
        end else begin
          // Request changes mid-byte are ignored; the byte always completes.
          cnt_d = cnt_q + 2'd1;
        end
      end
      StTrailer: begin
        if (tcnt_q == TrailLast) begin
          state_d = StIdle;
          tcnt_d  = 6'd0;
        end else begin
          tcnt_d = tcnt_q + 6'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state so every output is a plain register.
  always_comb begin
    en_d  = 1'b0;
    b1_d  = 1'b0;
    b2_d  = 1'b0;
    rdy_d = 1'b0;
    unique case (state_d)
      StSync: begin
        en_d  = 1'b1;
        b1_d  = SYNC_BYTE[{cnt_d, 1'b0}];
        b2_d  = SYNC_BYTE[{cnt_d, 1'b1}];
        rdy_d = (cnt_d == 2'd3);
      end
      StData: begin
        en_d  = 1'b1;
        b1_d  = shreg_d[{cnt_d, 1'b0}];
        b2_d  = shreg_d[{cnt_d, 1'b1}];
        rdy_d = (cnt_d == 2'd3);
      end
      StTrailer: begin
        en_d = 1'b1;
        b1_d = ~last_bit_d;
        b2_d = ~last_bit_d;
      end
      default: ;
    endcase
  end

  // State and output registers; reset aborts any burst without a trailer.
  always_ff @(posedge TX_DDR_clk or negedge TX_rst_n) begin
    if (!TX_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      tcnt_q     <= 6'd0;
      shreg_q    <= 8'd0;
      last_bit_q <= 1'b0;
      en_q       <= 1'b0;
      b1_q       <= 1'b0;
      b2_q       <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      shreg_q    <= shreg_d;
      last_bit_q <= last_bit_d;
      en_q       <= en_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      rdy_q      <= rdy_d;
    end
  end

  assign Enable    = en_q;
  assign Serial_B1 = b1_q;
  assign Serial_B2 = b2_q;
  assign TxReadyHS = rdy_q;

endmodule
